// File: rtl/ddio_tx_fsm.sv
// Burst transmitter next-state logic and datapath for a DDIO output pair; the state register lives outside.
// Optional LOAD-stall timeout is enabled by defining DDIO_TX_TIMEOUT_EN.
module ddio_tx_fsm #(
    parameter int nbr_states = 2,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nbr_states:0]   state_reg,
    output logic [nbr_states:0]   state_next,
    input  logic                  start,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_W/2-1:0]   dout_h,
    output logic [DATA_W/2-1:0]   dout_l,
    output logic                  dout_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int SW = nbr_states + 1;
    localparam int HW = DATA_W / 2;
    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    typedef enum logic [SW-1:0] {
        S_IDLE = SW'(0),
        S_LOAD = SW'(1),
        S_SEND = SW'(2),
        S_DONE = SW'(3)
    } state_e;

    logic [7:0]        word_cnt_q;
    logic [DATA_W-1:0] word_q;
    logic [HW-1:0]     dout_h_q;
    logic [HW-1:0]     dout_l_q;
    logic              dout_en_q;
    logic              done_q;
    logic              timeout_hit;

`ifdef DDIO_TX_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       err_q;

    assign timeout_hit = (to_cnt_q == 8'hFF);

    // Counts consecutive stalled LOAD cycles; any other cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_reg == S_LOAD && !din_valid && !timeout_hit)
                to_cnt_q <= to_cnt_q + 8'd1;
            else
                to_cnt_q <= '0;

            if (state_reg == S_LOAD && !din_valid && timeout_hit)
                err_q <= 1'b1;
            else if (state_reg == S_IDLE && start)
                err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next = S_IDLE;
        if (!rst) begin
            case (state_reg)
                S_IDLE:  state_next = start ? S_LOAD : S_IDLE;
                S_LOAD: begin
                    if (din_valid)
                        state_next = S_SEND;
                    else if (timeout_hit)
                        state_next = S_DONE;
                    else
                        state_next = S_LOAD;
                end
                S_SEND:  state_next = (word_cnt_q == LAST_IDX) ? S_DONE : S_LOAD;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            word_q     <= '0;
            dout_h_q   <= '0;
            dout_l_q   <= '0;
            dout_en_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dout_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_reg)
                S_IDLE: ;
                S_LOAD: begin
                    if (din_valid)
                        word_q <= din;
                end
                S_SEND: begin
                    dout_h_q   <= word_q[DATA_W-1:HW];
                    dout_l_q   <= word_q[HW-1:0];
                    dout_en_q  <= 1'b1;
                    word_cnt_q <= word_cnt_q + 8'd1;
                end
                S_DONE: begin
                    done_q     <= 1'b1;
                    word_cnt_q <= '0;
                end
                // Illegal codes fall back to IDLE, so the next burst starts clean.
                default: word_cnt_q <= '0;
            endcase
        end
    end

    assign din_ready = (state_reg == S_LOAD);
    assign busy      = (state_reg != S_IDLE);
    assign dout_h    = dout_h_q;
    assign dout_l    = dout_l_q;
    assign dout_en   = dout_en_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ddio_tx_fsm.sv
// Scoreboard bench for ddio_tx_fsm: bursts of random words, stalls, resets and illegal states.
module tb_ddio_tx_fsm;

    localparam int BL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (BURST_LEN = 8)
    logic        rst, start, din_valid, force_en;
    logic [15:0] din;
    logic [2:0]  force_val, state_q, state_reg, state_next;
    logic        din_ready, dout_en, busy, done, err;
    logic [7:0]  dout_h, dout_l;

    assign state_reg = force_en ? force_val : state_q;
    always @(posedge clk) state_q <= state_next;

    ddio_tx_fsm #(.nbr_states(2), .DATA_W(16), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .state_reg(state_reg), .state_next(state_next),
        .start(start), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout_h(dout_h), .dout_l(dout_l), .dout_en(dout_en), .busy(busy),
        .done(done), .err(err)
    );

    // Second instance (BURST_LEN = 1, start held high)
    logic        rst1, start1, dv1;
    logic [15:0] din1;
    logic [2:0]  st1_q, st1_next;
    logic        dr1, en1, busy1, done1, err1;
    logic [7:0]  dh1, dl1;

    always @(posedge clk) st1_q <= st1_next;

    ddio_tx_fsm #(.nbr_states(2), .DATA_W(16), .BURST_LEN(1)) u1 (
        .clk(clk), .rst(rst1), .state_reg(st1_q), .state_next(st1_next),
        .start(start1), .din(din1), .din_valid(dv1), .din_ready(dr1),
        .dout_h(dh1), .dout_l(dl1), .dout_en(en1), .busy(busy1),
        .done(done1), .err(err1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int en_cnt = 0, done_cnt = 0, last_done_cyc = 0;
    int en1_cnt = 0, done1_cnt = 0, last_en1 = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every dout_en pops one expected word
    always @(negedge clk) begin
        if (dout_en === 1'b1) begin
            en_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dout_unexpected got=%h exp=none", {dout_h, dout_l});
            end else begin
                mon_e = exp_q.pop_front();
                check("dout_word", 32'({dout_h, dout_l}), 32'(mon_e));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    // BURST_LEN=1 monitor: one word every 4 cycles
    always @(negedge clk) begin
        if (rst1 === 1'b0) begin
            if (en1 === 1'b1) begin
                if (last_en1 >= 0)
                    check("bl1_period", 32'(cyc - last_en1), 32'd4);
                check("bl1_word", 32'({dh1, dl1}), 32'(din1));
                last_en1 = cyc;
                en1_cnt++;
            end
            if (done1 === 1'b1)
                done1_cnt++;
        end
    end

    // Drives one burst; stops at done, at abort_en dout pulses, or at the guard.
    task automatic run_burst(input logic [15:0] base, input int gap_at, input int gap_len,
                             input int abort_en, output int lat, output int nw);
        int k, gl, d0, e0, guard, s;
        @(negedge clk); #1;
        start = 1'b1; din_valid = 1'b1; din = base;
        s = cyc; d0 = done_cnt; e0 = en_cnt; k = 0; gl = gap_len; lat = -1;
        @(negedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (guard < 2000) begin
            if (done_cnt != d0) begin
                lat = last_done_cyc - s;
                break;
            end
            if (abort_en > 0 && (en_cnt - e0) >= abort_en)
                break;
            if (gl > 0 && k == gap_at && (gl < gap_len || din_ready)) begin
                if (gl < gap_len) begin
                    check("stall_ready", 32'(din_ready), 32'd1);
                    check("stall_state", 32'(state_reg), 32'd1);
                end
                din_valid = 1'b0;
                gl--;
            end else if (din_ready) begin
                din_valid = 1'b1;
                din = base + 16'(k);
                exp_q.push_back(din);
                k++;
            end
            @(negedge clk); #1;
            guard++;
        end
        din_valid = 1'b1;
        nw = en_cnt - e0;
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL burst_timeout got=no_done exp=done");
        end
    endtask

    task automatic full_burst(input logic [15:0] base, input int gap_at, input int gap_len);
        int lat, nw, d0;
        d0 = done_cnt;
        run_burst(base, gap_at, gap_len, 0, lat, nw);
        check("latency", 32'(lat), 32'(2 * BL + 2 + gap_len));
        check("words", 32'(nw), 32'(BL));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        $display("burst base=%h gap=%0d@%0d lat=%0d words=%0d", base, gap_len, gap_at, lat, nw);
    endtask

    task automatic abort_check(input string tag);
        int d0;
        exp_q.delete();
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        $display("abort %s done_delta=%0d", tag, done_cnt - d0);
    endtask

    int lat, nw;

    initial begin
        rst = 1'b1; start = 1'b1; din_valid = 1'b1; din = 16'hFFFF;
        force_en = 1'b0; force_val = 3'd0;
        rst1 = 1'b1; start1 = 1'b0; dv1 = 1'b1; din1 = 16'h3C96;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state_next", 32'(state_next), 32'd0);
        check("rst_dout_en", 32'(dout_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'({dout_h, dout_l}), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd0);
        rst = 1'b0; start = 1'b0; rst1 = 1'b0; start1 = 1'b1;

        full_burst(16'hA5C3, -1, 0);
        full_burst(16'($urandom), 3, 5);
        for (int i = 0; i < 6; i++)
            full_burst(16'($urandom), int'($urandom_range(0, BL - 1)), int'($urandom_range(0, 6)));

        // Reset after the fourth word leaves
        run_burst(16'($urandom), -1, 0, 4, lat, nw);
        rst = 1'b1;
        #1;
        check("midrst_state_next", 32'(state_next), 32'd0);
        @(negedge clk); #1;
        check("midrst_dout_en", 32'(dout_en), 32'd0);
        check("midrst_dout", 32'({dout_h, dout_l}), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        abort_check("midrst");
        full_burst(16'($urandom), -1, 0);

        // Illegal codes 4..7
        for (int v = 4; v < 8; v++) begin
            @(negedge clk); #1;
            force_en = 1'b1; force_val = 3'(v);
            #1;
            check("illegal_next", 32'(state_next), 32'd0);
            check("illegal_busy", 32'(busy), 32'd1);
            @(negedge clk); #1;
            force_en = 1'b0;
            #1;
            check("illegal_after_busy", 32'(busy), 32'd0);
            $display("illegal state=%0d next=%0d", v, state_next);
        end

        // Illegal code mid-burst must restart the word count
        run_burst(16'($urandom), -1, 0, 3, lat, nw);
        force_en = 1'b1; force_val = 3'b110;
        @(negedge clk); #1;
        force_en = 1'b0;
        abort_check("midillegal");
        full_burst(16'($urandom), -1, 0);

`ifdef DDIO_TX_TIMEOUT_EN
        run_burst(16'($urandom), 0, 1000, 0, lat, nw);
        check("timeout_latency", 32'(lat), 32'd258);
        check("timeout_words", 32'(nw), 32'd0);
        check("timeout_err", 32'(err), 32'd1);
        $display("timeout lat=%0d err=%0d", lat, err);
        full_burst(16'($urandom), -1, 0);
        check("timeout_err_cleared", 32'(err), 32'd0);
`else
        check("err_tied", 32'(err), 32'd0);
`endif

        check("bl1_bursts", 32'(en1_cnt > 20), 32'd1);
        check("bl1_done_match", 32'((en1_cnt - done1_cnt) <= 1 && (done1_cnt - en1_cnt) <= 0), 32'd1);
        $display("bl1 en=%0d done=%0d", en1_cnt, done1_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
